// File: rtl/adder_pkg.sv
// Shared definitions for the segmented pipelined adder.
// Op encodings, default geometry and stage-count helper.
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SEG_W = 8;

    function automatic int stages(input int width, input int seg_w);
        return width / seg_w;
    endfunction

endpackage

// File: rtl/adder_seg.sv
// One carry-chain segment: SEG_W-bit add with carry-in,
// registered partial sum and carry-out, gated by the pipeline enable.
module adder_seg
    import adder_pkg::*;
#(
    parameter int SEG_W = DEF_SEG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             ci,
    output logic [SEG_W-1:0] s,
    output logic             co
);

    logic [SEG_W:0] r;

    assign r = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, ci};

    always_ff @(posedge clk) begin
        if (rst) begin
            s  <= '0;
            co <= 1'b0;
        end else if (en) begin
            s  <= r[SEG_W-1:0];
            co <= r[SEG_W];
        end
    end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract, one register stage per SEG_W-bit segment,
// with valid/ready handshakes and a global stall.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG_W = DEF_SEG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             ovf
);

    localparam int STAGES = stages(WIDTH, SEG_W);

    logic             en;
    logic             in_fire;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign en       = !out_valid | out_ready;
    assign in_ready = en & !rst;
    assign in_fire  = in_valid & in_ready;

    assign b_eff = (sub == OP_SUB) ? ~b : b;
    assign c0    = (sub == OP_ADD) ? cin : 1'b1;

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still unresolved when entering this stage.
        localparam int RW = WIDTH - k * SEG_W;

        logic [RW-1:0]          ain;
        logic [RW-1:0]          bin;
        logic                   ci;
        logic                   vin;
        logic                   vld;
        logic                   co;
        logic [SEG_W-1:0]       ps;
        logic [(k+1)*SEG_W-1:0] done;

        if (k == 0) begin : g_head
            assign ain  = a;
            assign bin  = b_eff;
            assign ci   = c0;
            assign vin  = in_fire;
            assign done = ps;
        end else begin : g_link
            logic [k*SEG_W-1:0] lo;

            assign ain  = g_stage[k-1].g_up.au;
            assign bin  = g_stage[k-1].g_up.bu;
            assign ci   = g_stage[k-1].co;
            assign vin  = g_stage[k-1].vld;
            assign done = {ps, lo};

            // Deskew: finished lower segments ride along.
            always_ff @(posedge clk) begin
                if (rst) begin
                    lo <= '0;
                end else if (en) begin
                    lo <= g_stage[k-1].done;
                end
            end
        end

        adder_seg #(
            .SEG_W(SEG_W)
        ) u_seg (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .a   (ain[SEG_W-1:0]),
            .b   (bin[SEG_W-1:0]),
            .ci  (ci),
            .s   (ps),
            .co  (co)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                vld <= 1'b0;
            end else if (en) begin
                vld <= vin;
            end
        end

        if (k < STAGES - 1) begin : g_up
            logic [RW-SEG_W-1:0] au;
            logic [RW-SEG_W-1:0] bu;

            always_ff @(posedge clk) begin
                if (en) begin
                    au <= ain[RW-1:SEG_W];
                    bu <= bin[RW-1:SEG_W];
                end
            end
        end else begin : g_tail
            // a^b_eff at the MSB; with the sum MSB it recovers the
            // carry into bit WIDTH-1.
            logic x;

            always_ff @(posedge clk) begin
                if (rst) begin
                    x <= 1'b0;
                end else if (en) begin
                    x <= ain[SEG_W-1] ^ bin[SEG_W-1];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld;
    assign sum       = g_stage[STAGES-1].done;
    assign carry_out = g_stage[STAGES-1].co;
    assign ovf       = g_stage[STAGES-1].g_tail.x ^ sum[WIDTH-1] ^ carry_out;

endmodule
